// File: rtl/dm_responder.sv
// dm_responder: data RAM for the CPU M-stage port with byte-lane writes,
// combinational reads, and a trace FIFO that logs every accepted write.
module dm_responder #(
  parameter int DEPTH_LOG2 = 12,
  parameter int TRACE_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic [3:0]  trace_byteen,
  output logic        overflow,
  output logic [15:0] drop_count,
  output logic        addr_err
);
  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam int TDEPTH = 1 << TRACE_LOG2;
  localparam logic [TRACE_LOG2:0] FULL_CNT = (TRACE_LOG2+1)'(TDEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } trace_t;

  logic [31:0]           r_ram [WORDS];
  trace_t                r_fifo [TDEPTH];
  logic [TRACE_LOG2-1:0] r_wp, r_rp;
  logic [TRACE_LOG2:0]   r_cnt;
  logic                  r_ovf, r_aerr;
  logic [15:0]           r_drop;

  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_in_range, w_wr, w_oor_wr;
  logic [31:0]           w_old, w_merged;
  logic                  w_full, w_pop, w_push, w_drop;
  trace_t                w_entry, w_head;

  assign w_idx      = m_data_addr[DEPTH_LOG2+1:2];
  assign w_in_range = (m_data_addr[31:DEPTH_LOG2+2] == '0);
  assign w_old      = r_ram[w_idx];
  assign w_wr       = (m_data_byteen != 4'b0000) && w_in_range;
  assign w_oor_wr   = (m_data_byteen != 4'b0000) && !w_in_range;

  // Merge enabled write lanes over the current word.
  always_comb begin
    w_merged = w_old;
    for (int i = 0; i < 4; i++)
      if (m_data_byteen[i]) w_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
  end

  // Read shows the pre-write value; out-of-range reads return zero.
  assign m_data_rdata = w_in_range ? w_old : 32'h0;

  // Word RAM: cleared on reset, byte-lane merged write otherwise.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) r_ram[i] <= 32'h0;
    end else if (w_wr) begin
      r_ram[w_idx] <= w_merged;
    end
  end

  // FIFO handshake: a pop frees a slot for a same-cycle push even when full.
  assign trace_valid = (r_cnt != '0);
  assign w_full      = (r_cnt == FULL_CNT);
  assign w_pop       = trace_valid && trace_ready;
  assign w_push      = w_wr && (!w_full || w_pop);
  assign w_drop      = w_wr && w_full && !w_pop;

  assign w_entry.pc   = m_inst_addr;
  assign w_entry.addr = {m_data_addr[31:2], 2'b00};
  assign w_entry.data = w_merged;
  assign w_entry.be   = m_data_byteen;

  assign w_head       = r_fifo[r_rp];
  assign trace_pc     = trace_valid ? w_head.pc   : 32'h0;
  assign trace_addr   = trace_valid ? w_head.addr : 32'h0;
  assign trace_data   = trace_valid ? w_head.data : 32'h0;
  assign trace_byteen = trace_valid ? w_head.be   : 4'h0;

  // Trace storage; contents are only observed while the entry is live.
  always_ff @(posedge clk) begin
    if (reset && w_push) r_fifo[r_wp] <= w_entry;
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Sticky error flags and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ovf  <= 1'b0;
      r_aerr <= 1'b0;
      r_drop <= 16'h0;
    end else begin
      if (w_oor_wr) r_aerr <= 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != 16'hFFFF) r_drop <= r_drop + 16'h1;
      end
    end
  end

  assign overflow   = r_ovf;
  assign drop_count = r_drop;
  assign addr_err   = r_aerr;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: behavioural RAM model plus a scoreboard queue of
// expected trace entries, checked at the falling edge of every cycle.
module tb_dm_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_data_addr, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        trace_ready;
  logic [31:0] m_data_rdata, trace_pc, trace_addr, trace_data;
  logic [3:0]  trace_byteen;
  logic        trace_valid, overflow, addr_err;
  logic [15:0] drop_count;

  dm_responder dut (
    .clk(clk), .reset(reset),
    .m_data_addr(m_data_addr), .m_data_wdata(m_data_wdata),
    .m_data_byteen(m_data_byteen), .m_inst_addr(m_inst_addr),
    .m_data_rdata(m_data_rdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
    .trace_byteen(trace_byteen),
    .overflow(overflow), .drop_count(drop_count), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, addr, data;
    logic [3:0]  be;
  } ent_t;

  logic [31:0] mram [int];
  ent_t        q [$];
  logic        m_ovf, m_aerr;
  logic [15:0] m_drop;
  int          n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    int idx;
    idx = int'(a[13:2]);
    if (a[31:14] != 18'h0) return 32'h0;
    return mram.exists(idx) ? mram[idx] : 32'h0;
  endfunction

  function automatic void mreset();
    mram.delete();
    q.delete();
    m_ovf  = 1'b0;
    m_aerr = 1'b0;
    m_drop = 16'h0;
  endfunction

  // One clock: drive, check at negedge, advance the model at the edge.
  task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] pc, input logic rdy, input logic rst_n);
    logic [31:0] mw;
    logic        inr;
    ent_t        e;
    m_data_addr = a; m_data_wdata = wd; m_data_byteen = be;
    m_inst_addr = pc; trace_ready = rdy; reset = rst_n;
    @(negedge clk);
    chk("rdata", m_data_rdata, mrd(a));
    chk("valid", {31'h0, trace_valid}, {31'h0, q.size() != 0});
    if (q.size() != 0) begin
      chk("t_pc",   trace_pc,   q[0].pc);
      chk("t_addr", trace_addr, q[0].addr);
      chk("t_data", trace_data, q[0].data);
      chk("t_be",   {28'h0, trace_byteen}, {28'h0, q[0].be});
    end
    chk("ovf",  {31'h0, overflow}, {31'h0, m_ovf});
    chk("drop", {16'h0, drop_count}, {16'h0, m_drop});
    chk("aerr", {31'h0, addr_err}, {31'h0, m_aerr});
    @(posedge clk);
    if (!rst_n) begin
      mreset();
    end else begin
      inr = (a[31:14] == 18'h0);
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (be != 4'h0 && !inr) m_aerr = 1'b1;
      if (be != 4'h0 && inr) begin
        mw = mrd(a);
        for (int i = 0; i < 4; i++) if (be[i]) mw[8*i +: 8] = wd[8*i +: 8];
        mram[int'(a[13:2])] = mw;
        e.pc = pc; e.addr = {a[31:2], 2'b00}; e.data = mw; e.be = be;
        if (q.size() < 8) q.push_back(e);
        else begin
          m_ovf = 1'b1;
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'h1;
        end
      end
    end
    #1;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && q.size() != 0; i++) cyc(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    chk("drained", {31'h0, trace_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] a;
    reset = 1'b0; m_data_addr = 0; m_data_wdata = 0; m_data_byteen = 0;
    m_inst_addr = 0; trace_ready = 0;
    mreset();
    repeat (2) begin @(posedge clk); #1; end
    cyc(32'h10, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Full-word store, then byte store on the same word.
    cyc(32'h10, 32'h12345678, 4'hF, 32'h3000, 1'b0, 1'b1);
    m_data_byteen = 4'h0; #1;
    chk("t1_rd",   m_data_rdata, 32'h12345678);
    chk("t1_pc",   trace_pc,     32'h3000);
    chk("t1_addr", trace_addr,   32'h10);
    chk("t1_be",   {28'h0, trace_byteen}, 32'hF);
    cyc(32'h12, 32'h00AB0000, 4'h4, 32'h3004, 1'b1, 1'b1);
    m_data_addr = 32'h10; m_data_byteen = 4'h0; #1;
    chk("t2_rd",   m_data_rdata, 32'h12AB5678);
    chk("t2_data", trace_data,   32'h12AB5678);
    chk("t2_addr", trace_addr,   32'h10);
    drain(20);

    // Ten stores with the logger stalled: eight kept, two dropped.
    for (int k = 0; k < 10; k++)
      cyc(32'h100 + 4*k, 32'hA000_0000 + k, 4'hF, 32'h4000 + 4*k, 1'b0, 1'b1);
    m_data_byteen = 4'h0; #1;
    chk("ovf10",  {31'h0, overflow}, 32'h1);
    chk("drop10", {16'h0, drop_count}, 32'h2);
    chk("head10", trace_data, 32'hA000_0000);
    drain(20);

    // Full FIFO with push and pop together: nothing dropped.
    for (int k = 0; k < 8; k++)
      cyc(32'h200 + 4*k, 32'hB000_0000 + k, 4'hF, 32'h5000 + 4*k, 1'b0, 1'b1);
    cyc(32'h240, 32'hC0DE_0001, 4'hF, 32'h6000, 1'b1, 1'b1);
    m_data_byteen = 4'h0; #1;
    chk("pp_drop", {16'h0, drop_count}, 32'h2);
    chk("pp_head", trace_data, 32'hB000_0001);
    for (int k = 0; k < 7; k++) cyc(32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    chk("pp_last", trace_data, 32'hC0DE_0001);
    drain(20);

    // Out-of-range store is dropped and flagged.
    cyc(32'h4000, 32'hDEADBEEF, 4'hF, 32'h7000, 1'b0, 1'b1);
    m_data_byteen = 4'h0; #1;
    chk("oor_err", {31'h0, addr_err}, 32'h1);
    chk("oor_rd",  m_data_rdata, 32'h0);
    chk("oor_tv",  {31'h0, trace_valid}, 32'h0);
    m_data_addr = 32'h0; #1;
    chk("oor_w0",  m_data_rdata, 32'h0);

    // Randomised traffic with stalls and occasional out-of-range stores.
    for (int k = 0; k < 300; k++) begin
      a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | 32'h8000_4000;
      cyc(a, $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0, 1'b1);
    end

    // Reset with a store in flight clears everything.
    for (int k = 0; k < 10; k++)
      cyc(32'h300 + 4*k, 32'h5555_0000 + k, 4'hF, 32'h8000, 1'b0, 1'b1);
    cyc(32'h4000, 32'h1, 4'hF, 32'h0, 1'b0, 1'b1);
    cyc(32'h304, 32'hFFFF_FFFF, 4'hF, 32'h9000, 1'b0, 1'b0);
    m_data_byteen = 4'h0; #1;
    chk("rst_rd",   m_data_rdata, 32'h0);
    chk("rst_tv",   {31'h0, trace_valid}, 32'h0);
    chk("rst_ovf",  {31'h0, overflow}, 32'h0);
    chk("rst_drop", {16'h0, drop_count}, 32'h0);
    chk("rst_aerr", {31'h0, addr_err}, 32'h0);
    for (int k = 0; k < 10; k++) cyc(32'h300 + 4*k, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    cyc(32'h10, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
